vga_frame_reader: RTL and testbench

Display-side read stage between the VGA timing generator and the VGA-to-HDMI encoder, in the pixel clock domain. It generates frame-buffer read addresses incrementally, with no multiplier, and absorbs the BRAM read latency. It delays hsync/vsync/de so they stay aligned with returned pixel data, and drives 4-bit grayscale onto all three colour channels. Per-frame controls select either a gray-bar test pattern or blanked output, and the block exposes frame and line-length health status.

---
 rtl/vga_frame_reader.sv | 136 +++++++++++++
 tb/tb_vga_frame_reader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// Display-side frame-buffer read stage: incremental read addressing, BRAM latency
// absorption, sync/de alignment, gray-bar test pattern and line/frame health status.
module vga_frame_reader #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              de_in,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic              display_en,
  input  logic              pattern_sel,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              hsync,
  output logic              vsync,
  output logic              vde,
  output logic [15:0]       frame_count,
  output logic              line_err
);
  localparam int L = READ_LATENCY + 2;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int LC_W = $clog2(H_ACTIVE + 2) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  logic              w_sof;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_next_addr;
  logic              r_en_q;
  logic              r_pat_q;
  logic [15:0]       r_frame_count;
  logic [L-1:0]      r_hs_dly;
  logic [L-1:0]      r_vs_dly;
  logic [L-1:0]      r_de_dly;
  logic [9:0]        r_x_dly [L-1];
  logic [2:0]        w_bar;
  logic [3:0]        w_gray;
  logic [3:0]        r_gray;
  logic [LC_W-1:0]   r_line_cnt;
  logic              r_de_prev;
  logic              r_line_err;

  assign w_sof = de_in && (draw_x == 10'd0) && (draw_y == 10'd0);

  // SOF takes priority over the running count so a timing glitch re-anchors the frame.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      r_rd_addr     <= '0;
      r_next_addr   <= '0;
      r_en_q        <= 1'b0;
      r_pat_q       <= 1'b0;
      r_frame_count <= '0;
    end else if (w_sof) begin
      r_rd_addr     <= '0;
      r_next_addr   <= ADDR_W'(1);
      r_en_q        <= display_en;
      r_pat_q       <= pattern_sel;
      r_frame_count <= r_frame_count + 16'd1;
    end else if (de_in) begin
      r_rd_addr <= r_next_addr;
      if (r_next_addr != LAST_ADDR) r_next_addr <= r_next_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      r_hs_dly <= '0;
      r_vs_dly <= '0;
      r_de_dly <= '0;
      for (int i = 0; i < L - 1; i++) r_x_dly[i] <= '0;
    end else begin
      r_hs_dly   <= {r_hs_dly[L-2:0], hs_in};
      r_vs_dly   <= {r_vs_dly[L-2:0], vs_in};
      r_de_dly   <= {r_de_dly[L-2:0], de_in};
      r_x_dly[0] <= draw_x;
      for (int i = 1; i < L - 1; i++) r_x_dly[i] <= r_x_dly[i-1];
    end
  end

  // Stage L-2 lines up with rd_data; the output register supplies the last stage.
  always_comb begin
    w_bar = '0;
    for (int k = 1; k < 8; k++)
      if (r_x_dly[L-2] >= 10'(k * BAR_W)) w_bar = 3'(k);
  end

  always_comb begin
    w_gray = '0;
    if (r_de_dly[L-2]) begin
      if (r_pat_q)     w_gray = {w_bar, 1'b1};
      else if (r_en_q) w_gray = 4'(rd_data);
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) r_gray <= '0;
    else       r_gray <= w_gray;
  end

  // Run length saturates so an overlong line can never alias back to H_ACTIVE.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      r_line_cnt <= '0;
      r_de_prev  <= 1'b0;
      r_line_err <= 1'b0;
    end else begin
      r_de_prev <= de_in;
      if (de_in) begin
        if (r_line_cnt != '1) r_line_cnt <= r_line_cnt + LC_W'(1);
      end else if (r_de_prev) begin
        if (r_line_cnt != LC_W'(H_ACTIVE)) r_line_err <= 1'b1;
        r_line_cnt <= '0;
      end
    end
  end

  assign rd_addr     = r_rd_addr;
  assign red         = r_gray;
  assign green       = r_gray;
  assign blue        = r_gray;
  assign hsync       = r_hs_dly[L-1];
  assign vsync       = r_vs_dly[L-1];
  assign vde         = r_de_dly[L-1];
  assign frame_count = r_frame_count;
  assign line_err    = r_line_err;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: three instances (read latency 1, 2, 4) on a reduced
// raster, compared every cycle against a cycle-history reference model.
module tb_vga_frame_reader;
  localparam int H  = 64;
  localparam int V  = 6;
  localparam int AW = 9;
  localparam int HT = 80;
  localparam int VT = 9;
  localparam int HN = 16384;
  localparam int MAXA = H * V - 1;

  typedef struct packed {
    logic       rst;
    logic       de;
    logic       hs;
    logic       vs;
    logic [3:0] gray;
  } hist_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          hs_in = 1'b1;
  logic          vs_in = 1'b1;
  logic          de_in = 1'b0;
  logic [9:0]    draw_x = '0;
  logic [9:0]    draw_y = '0;
  logic          display_en = 1'b0;
  logic          pattern_sel = 1'b0;
  logic [AW-1:0] rd_addr [3];
  logic [3:0]    rd_data [3];
  logic [3:0]    red [3];
  logic [3:0]    green [3];
  logic [3:0]    blue [3];
  logic          hsync [3];
  logic          vsync [3];
  logic          vde [3];
  logic [15:0]   frame_count [3];
  logic          line_err [3];

  logic [3:0] mem [1 << AW];
  hist_t      hist [HN];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int first_de = -1;
  int first_vde [3] = '{-1, -1, -1};

  int   m_addr = 0;
  int   m_pix = 0;
  logic m_en = 1'b0;
  logic m_pat = 1'b0;
  int   m_fc = 0;
  int   m_run = 0;
  logic m_prev = 1'b0;
  logic m_err = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int RL = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    logic [3:0] bq [4];

    vga_frame_reader #(
      .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(4), .READ_LATENCY(RL)
    ) u_dut (
      .pixel_clk(clk), .reset(reset), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
      .draw_x(draw_x), .draw_y(draw_y), .display_en(display_en),
      .pattern_sel(pattern_sel), .rd_addr(rd_addr[g]), .rd_data(rd_data[g]),
      .red(red[g]), .green(green[g]), .blue(blue[g]), .hsync(hsync[g]),
      .vsync(vsync[g]), .vde(vde[g]), .frame_count(frame_count[g]),
      .line_err(line_err[g])
    );

    // Frame-buffer model: data for an address appears RL cycles after it.
    always @(posedge clk) begin
      bq[0] <= mem[rd_addr[g]];
      for (int k = 1; k < 4; k++) bq[k] <= bq[k-1];
    end
    assign rd_data[g] = bq[RL-1];
  end

  function automatic int lat(input int g);
    return (g == 0) ? 3 : ((g == 1) ? 4 : 6);
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    for (int g = 0; g < 3; g++) begin
      int    t;
      bit    blank;
      hist_t h;
      t = cyc - lat(g);
      blank = 0;
      for (int k = t; k < cyc; k++)
        if (k < 0 || hist[k].rst) blank = 1;
      if (blank) h = '0;
      else       h = hist[t];
      chk($sformatf("red%0d", g),   int'(red[g]),   int'(h.gray));
      chk($sformatf("green%0d", g), int'(green[g]), int'(h.gray));
      chk($sformatf("blue%0d", g),  int'(blue[g]),  int'(h.gray));
      chk($sformatf("hsync%0d", g), int'(hsync[g]), int'(h.hs));
      chk($sformatf("vsync%0d", g), int'(vsync[g]), int'(h.vs));
      chk($sformatf("vde%0d", g),   int'(vde[g]),   int'(h.de));
      chk($sformatf("rd_addr%0d", g), int'(rd_addr[g]), m_addr);
      chk($sformatf("frame_count%0d", g), int'(frame_count[g]), m_fc);
      chk($sformatf("line_err%0d", g), int'(line_err[g]), int'(m_err));
      if (vde[g] && first_vde[g] < 0) first_vde[g] = cyc;
    end
  endtask

  // Reference model: per-frame mode, address = active pixels since SOF (clamped),
  // line lengths measured between de falls.
  task automatic model_update();
    hist_t h;
    bit    sof;
    h.rst = reset;
    h.de = de_in;
    h.hs = hs_in;
    h.vs = vs_in;
    h.gray = '0;
    if (reset) begin
      m_addr = 0; m_pix = 0; m_en = 0; m_pat = 0; m_fc = 0;
      m_run = 0; m_prev = 0; m_err = 0;
    end else begin
      sof = de_in && draw_x == 0 && draw_y == 0;
      if (de_in && first_de < 0) first_de = cyc;
      if (sof) begin
        m_en = display_en;
        m_pat = pattern_sel;
        m_fc = (m_fc + 1) % 65536;
        m_pix = 0;
      end
      if (de_in) begin
        m_addr = (m_pix > MAXA) ? MAXA : m_pix;
        m_pix++;
        if (m_pat)     h.gray = 4'(2 * (int'(draw_x) / (H / 8)) + 1);
        else if (m_en) h.gray = mem[m_addr];
      end
      if (de_in) m_run++;
      else if (m_prev) begin
        if (m_run != H) m_err = 1;
        m_run = 0;
      end
      m_prev = de_in;
    end
    hist[cyc] = h;
  endtask

  task automatic step(input logic r, input int x, input int y, input logic de,
                      input logic en, input logic pat);
    @(posedge clk);
    #1;
    if (cyc >= HN) begin
      $display("FAIL cycle_budget got %0d expected below %0d", cyc, HN);
      $fatal(1, "cycle budget exhausted");
    end
    check_outputs();
    reset = r;
    draw_x = 10'(x);
    draw_y = 10'(y);
    de_in = de;
    hs_in = !(x >= H + 4 && x < H + 10);
    vs_in = !(y == V + 1);
    display_en = en;
    pattern_sel = pat;
    model_update();
    cyc++;
  endtask

  task automatic run_frame(input int act_lines, input int short_line, input bit glitch,
                           input int rst_line, input logic en0, input logic pat0,
                           input int chg_line, input logic en1, input logic pat1);
    int   x;
    int   y;
    bit   gl;
    logic en;
    logic pat;
    logic r;
    logic de;
    x = 0; y = 0; gl = glitch; en = en0; pat = pat0;
    while (y < VT) begin
      if (gl && y == 3 && x == 20) begin
        x = 0; y = 0; gl = 0;
      end
      if (x == 0 && y == chg_line) begin
        en = en1; pat = pat1;
      end
      r = (y == rst_line) && (x == H + 2 || x == H + 3);
      de = (y < act_lines) && (x < ((y == short_line) ? H - 1 : H));
      step(r, x, y, de, en, pat);
      x++;
      if (x == HT) begin
        x = 0; y++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 4'($urandom);
    repeat (4) step(1, 0, 0, 0, 0, 0);
    run_frame(V, -1, 0, -1, 1, 0, -1, 0, 0);
    chk("last_addr", int'(rd_addr[1]), MAXA);
    for (int g = 0; g < 3; g++)
      chk($sformatf("vde_lag%0d", g), first_vde[g] - first_de, lat(g));
    run_frame(V, -1, 0, -1, 1, 0, 2, 1, 1);
    run_frame(V, -1, 0, -1, 1, 1, -1, 0, 0);
    run_frame(V, -1, 0, -1, 0, 0, 3, 1, 0);
    repeat (3)
      run_frame(V, -1, 0, -1, 1'($urandom), 1'($urandom), $urandom_range(0, V - 1),
                1'($urandom), 1'($urandom));
    run_frame(V + 1, -1, 0, -1, 1, 0, -1, 0, 0);
    chk("sat_addr", int'(rd_addr[1]), MAXA);
    chk("line_err_clean", int'(line_err[1]), 0);
    run_frame(V, 2, 0, -1, 1, 0, -1, 0, 0);
    chk("line_err_set", int'(line_err[1]), 1);
    run_frame(V, -1, 1, -1, 1, 0, -1, 0, 0);
    chk("line_err_sticky", int'(line_err[1]), 1);
    run_frame(V, -1, 0, 3, 1, 0, -1, 0, 0);
    chk("fc_after_reset", int'(frame_count[1]), 0);
    chk("line_err_cleared", int'(line_err[1]), 0);
    run_frame(V, -1, 0, -1, 1, 1'($urandom), -1, 0, 0);
    chk("fc_restart", int'(frame_count[1]), 1);
    repeat (8) step(0, 0, VT, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
